// File: rtl/gate_exerciser_pkg.sv
// Shared definitions for the gate exerciser: FSM state encoding, named truth
// tables for common gates, and the settle-timer width helper.
package gate_exerciser_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   localparam logic [3:0] TRUTH_OR2  = 4'b1110;
   localparam logic [3:0] TRUTH_AND2 = 4'b1000;
   localparam logic [3:0] TRUTH_XOR2 = 4'b0110;
   localparam logic [7:0] TRUTH_OR3  = 8'b1111_1110;
   localparam logic [7:0] TRUTH_AND3 = 8'b1000_0000;
   localparam logic [7:0] TRUTH_XOR3 = 8'b1001_0110;

   // Counter width able to hold SETTLE-1; never narrower than one bit.
   function automatic int unsigned timer_width(input int unsigned settle);
      if (settle > 32'd2) begin
         return $clog2(settle);
      end else begin
         return 32'd1;
      end
   endfunction

endpackage

// File: rtl/gate_exerciser_settle_timer.sv
// Loadable down-counter with zero flag; times how long stim is held before
// the gate output is sampled.
module settle_timer
   import gate_exerciser_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Load takes priority; decrement stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != {WIDTH{1'b0}})) begin
         cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {WIDTH{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/gate_exerciser.sv
// Sweeps every input vector into a combinational gate, samples its output
// after a settle time and checks it against a truth table.
module gate_exerciser
   import gate_exerciser_pkg::*;
#(
   parameter int unsigned                   N_IN   = 2,
   parameter logic [(32'd1 << N_IN)-1:0]    TRUTH  = TRUTH_OR2,
   parameter int unsigned                   SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            resp,
   output logic [N_IN-1:0] stim,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_cnt,
   output logic            fail_valid,
   output logic [N_IN-1:0] first_fail_vec
);

   localparam int unsigned     TW        = timer_width(SETTLE);
   localparam logic [TW-1:0]   SETTLE_LD = TW'(SETTLE - 32'd1);
   localparam logic [N_IN-1:0] STIM_ONE  = N_IN'(1'b1);
   localparam logic [N_IN-1:0] STIM_MAX  = {N_IN{1'b1}};
   localparam logic [N_IN:0]   ERR_ONE   = (N_IN + 1)'(1'b1);

   state_e          state_q, state_d;
   logic [N_IN-1:0] stim_q, stim_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [N_IN:0]   err_cnt_q, err_cnt_d;
   logic            fail_valid_q, fail_valid_d;
   logic [N_IN-1:0] first_fail_vec_q, first_fail_vec_d;
   logic            tmr_load;
   logic            tmr_en;
   logic            tmr_zero;
   logic            mismatch;

   settle_timer #(.WIDTH(TW)) u_settle_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (SETTLE_LD),
      .en       (tmr_en),
      .zero     (tmr_zero)
   );

   assign mismatch = (resp != TRUTH[stim_q]);

   // Next-state, stimulus and result update logic.
   always_comb begin
      state_d          = state_q;
      stim_d           = stim_q;
      busy_d           = busy_q;
      done_d           = 1'b0;
      pass_d           = pass_q;
      err_cnt_d        = err_cnt_q;
      fail_valid_d     = fail_valid_q;
      first_fail_vec_d = first_fail_vec_q;
      tmr_load         = 1'b0;
      tmr_en           = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d          = S_SETTLE;
               stim_d           = {N_IN{1'b0}};
               busy_d           = 1'b1;
               pass_d           = 1'b0;
               err_cnt_d        = {(N_IN+1){1'b0}};
               fail_valid_d     = 1'b0;
               first_fail_vec_d = {N_IN{1'b0}};
               tmr_load         = 1'b1;
            end else begin
               stim_d = {N_IN{1'b0}};
            end
         end
         S_SETTLE: begin
            if (tmr_zero) begin
               state_d = S_SAMPLE;
            end else begin
               tmr_en = 1'b1;
            end
         end
         S_SAMPLE: begin
            if (mismatch) begin
               err_cnt_d = err_cnt_q + ERR_ONE;
               if (!fail_valid_q) begin
                  fail_valid_d     = 1'b1;
                  first_fail_vec_d = stim_q;
               end else begin
                  fail_valid_d = fail_valid_q;
               end
            end else begin
               err_cnt_d = err_cnt_q;
            end
            // The sweep ends at the all-ones vector rather than wrapping.
            if (stim_q != STIM_MAX) begin
               stim_d   = stim_q + STIM_ONE;
               state_d  = S_SETTLE;
               tmr_load = 1'b1;
            end else begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_cnt_d == {(N_IN+1){1'b0}});
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            stim_d  = {N_IN{1'b0}};
         end
         default: begin
            state_d = S_IDLE;
            stim_d  = {N_IN{1'b0}};
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset discards any partial sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         stim_q           <= {N_IN{1'b0}};
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         pass_q           <= 1'b0;
         err_cnt_q        <= {(N_IN+1){1'b0}};
         fail_valid_q     <= 1'b0;
         first_fail_vec_q <= {N_IN{1'b0}};
      end else begin
         state_q          <= state_d;
         stim_q           <= stim_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         pass_q           <= pass_d;
         err_cnt_q        <= err_cnt_d;
         fail_valid_q     <= fail_valid_d;
         first_fail_vec_q <= first_fail_vec_d;
      end
   end

   assign stim           = stim_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_cnt        = err_cnt_q;
   assign fail_valid     = fail_valid_q;
   assign first_fail_vec = first_fail_vec_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: a default 2-input instance and a 3-input, SETTLE=3
// instance, each driven by a table-defined gate and checked against a model.
module tb_gate_exerciser;

   logic       clk = 1'b0;
   logic       rst;
   logic       start0, start1;
   logic       resp0, resp1;
   logic [3:0] tbl0;
   logic [7:0] tbl1;

   logic [1:0] stim0, ffv0;
   logic [2:0] err0;
   logic       busy0, done0, pass0, fv0;
   logic [2:0] stim1, ffv1;
   logic [3:0] err1;
   logic       busy1, done1, pass1, fv1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign resp0 = tbl0[stim0];
   assign resp1 = tbl1[stim1];

   gate_exerciser dut0 (
      .clk(clk), .rst(rst), .start(start0), .resp(resp0), .stim(stim0),
      .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
      .fail_valid(fv0), .first_fail_vec(ffv0)
   );

   gate_exerciser #(.N_IN(3), .TRUTH(8'b1111_1110), .SETTLE(3)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .resp(resp1), .stim(stim1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
      .fail_valid(fv1), .first_fail_vec(ffv1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input int which, input bit v);
      if (which == 1) start1 = v;
      else start0 = v;
   endtask

   // One full sweep; expectations come from the gate table versus the truth table.
   task automatic sweep(input int which, input logic [7:0] tbl, input bit hold,
                        input bit noise, input string nm);
      int n, s, len, nvec, exp_err, exp_first;
      logic [7:0]  truth;
      logic [31:0] o_stim, o_busy, o_done, o_pass, o_err, o_fv, o_ffv;
      n     = (which == 1) ? 3 : 2;
      s     = (which == 1) ? 3 : 1;
      truth = (which == 1) ? 8'b1111_1110 : 8'b0000_1110;
      nvec  = 1 << n;
      len   = nvec * (s + 1) + 1;
      exp_err   = 0;
      exp_first = -1;
      for (int v = 0; v < nvec; v++) begin
         if (tbl[v] != truth[v]) begin
            exp_err++;
            if (exp_first < 0) exp_first = v;
         end
      end
      if (exp_first < 0) exp_first = 0;
      if (which == 1) tbl1 = tbl;
      else tbl0 = tbl[3:0];
      set_start(which, 1'b1);
      for (int k = 1; k <= len + 1; k++) begin
         step();
         if (k == len + 1) set_start(which, hold);
         if (which == 1) begin
            o_stim = {29'd0, stim1}; o_busy = {31'd0, busy1}; o_done = {31'd0, done1};
            o_pass = {31'd0, pass1}; o_err = {28'd0, err1}; o_fv = {31'd0, fv1};
            o_ffv = {29'd0, ffv1};
         end else begin
            o_stim = {30'd0, stim0}; o_busy = {31'd0, busy0}; o_done = {31'd0, done0};
            o_pass = {31'd0, pass0}; o_err = {29'd0, err0}; o_fv = {31'd0, fv0};
            o_ffv = {30'd0, ffv0};
         end
         if (k < len) begin
            chk($sformatf("%s c%0d stim", nm, k), o_stim, (k - 1) / (s + 1));
            chk($sformatf("%s c%0d busy", nm, k), o_busy, 1);
            chk($sformatf("%s c%0d done", nm, k), o_done, 0);
         end else if (k == len) begin
            chk($sformatf("%s c%0d done", nm, k), o_done, 1);
            chk($sformatf("%s c%0d busy", nm, k), o_busy, 0);
            chk($sformatf("%s err_cnt", nm), o_err, exp_err);
            chk($sformatf("%s fail_valid", nm), o_fv, (exp_err > 0) ? 1 : 0);
            chk($sformatf("%s first_fail", nm), o_ffv, exp_first);
            chk($sformatf("%s pass", nm), o_pass, (exp_err == 0) ? 1 : 0);
         end else begin
            chk($sformatf("%s idle stim", nm), o_stim, 0);
            chk($sformatf("%s idle busy", nm), o_busy, 0);
            chk($sformatf("%s idle done", nm), o_done, 0);
            chk($sformatf("%s hold err_cnt", nm), o_err, exp_err);
         end
         if (k == 1) begin
            chk($sformatf("%s clr err_cnt", nm), o_err, 0);
            chk($sformatf("%s clr fail_valid", nm), o_fv, 0);
            chk($sformatf("%s clr pass", nm), o_pass, 0);
         end
         if (k < len + 1) set_start(which, hold || (noise && (k == 3 || k == len)));
      end
   endtask

   initial begin
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; tbl0 = 4'b0000; tbl1 = 8'h00;
      step();
      step();
      chk("rst stim0", {30'd0, stim0}, 0);
      chk("rst busy0", {31'd0, busy0}, 0);
      chk("rst done0", {31'd0, done0}, 0);
      chk("rst pass0", {31'd0, pass0}, 0);
      chk("rst err0", {29'd0, err0}, 0);
      chk("rst fv0", {31'd0, fv0}, 0);
      chk("rst ffv0", {30'd0, ffv0}, 0);
      chk("rst busy1", {31'd0, busy1}, 0);
      chk("rst err1", {28'd0, err1}, 0);
      rst = 1'b0;
      step();

      sweep(0, 8'b0000_1110, 1'b0, 1'b0, "or2");
      sweep(0, 8'b0000_0000, 1'b0, 1'b0, "zero");
      sweep(0, 8'b0000_1000, 1'b0, 1'b0, "and2");

      // Reset in the middle of a sweep with one error already counted.
      tbl0 = 4'b1111;
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      step(); step(); step();
      chk("midrst pre err", {29'd0, err0}, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst busy", {31'd0, busy0}, 0);
      chk("midrst stim", {30'd0, stim0}, 0);
      chk("midrst err", {29'd0, err0}, 0);
      chk("midrst fv", {31'd0, fv0}, 0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("midrst quiet%0d", i), {30'd0, done0, busy0}, 0);
      end
      sweep(0, 8'b0000_1110, 1'b0, 1'b0, "after_rst");

      sweep(0, 8'b0000_1110, 1'b0, 1'b1, "noise");
      step();
      chk("noise no queue", {31'd0, busy0}, 0);

      sweep(0, 8'b0000_1110, 1'b1, 1'b0, "hold1");
      sweep(0, 8'b0000_0110, 1'b1, 1'b0, "hold2");
      start0 = 1'b0;
      step();
      chk("hold end busy", {31'd0, busy0}, 0);

      for (int r = 0; r < 4; r++) begin
         sweep(0, {4'b0000, 4'($urandom_range(0, 15))}, 1'b0, 1'b0, $sformatf("rnd2_%0d", r));
      end

      sweep(1, 8'b1111_1110, 1'b0, 1'b0, "or3");
      sweep(1, 8'b1000_0000, 1'b0, 1'b0, "and3");
      for (int r = 0; r < 3; r++) begin
         sweep(1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, $sformatf("rnd3_%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
